// File: rtl/aec_expr_tx.sv
// ---------------------------------------------------------------------------
// aec_expr_tx
//
// Collects an arithmetic expression as a stream of 5-bit tokens and sends it
// as ASCII characters, followed by '='. It then waits for the downstream
// calculator's result.
//
// Configuration macro: AEC_TX_CHECK_EN
//   When defined, each expression is syntax-checked in one cycle on its final
//   token. A rejected expression pulses err and is discarded.
//   When undefined, expressions are sent verbatim and err is tied low.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   tok_wr     token write strobe (honoured only in IDLE)
//   tok_in     token code: 0-15 hex digit, 16 '(', 17 ')', 18 '*',
//              19 '+', 20 '-', 21-31 reserved (dropped)
//   tok_last   marks the final token of an expression
//   res_valid  result strobe from the calculator (honoured only in WAIT_RES)
//   res_in     calculator result
//   ready      pulse coincident with the first character of an expression
//   ascii_out  transmitted character, 0x00 when not sending
//   busy       high in SEND, EQ and WAIT_RES
//   done       pulse when a result is captured
//   result     last captured result
//   err        pulse on a rejected expression
// ---------------------------------------------------------------------------
module aec_expr_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_wr,
  input  logic [4:0] tok_in,
  input  logic       tok_last,
  input  logic       res_valid,
  input  logic [6:0] res_in,
  output logic       ready,
  output logic [7:0] ascii_out,
  output logic       busy,
  output logic       done,
  output logic [6:0] result,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SEND, EQ, WAIT_RES} state_t;

  state_t     state_reg;
  logic [4:0] tok_buf_reg [16];
  logic [4:0] count_reg;   // stored tokens, 0..16
  logic [4:0] idx_reg;     // next token to send, 1..16

  logic       wr_accept;
  logic [4:0] count_after;
  logic       end_req;
  logic [4:0] first_tok;
  logic       chk_ok;

  function automatic logic [7:0] tok_char(input logic [4:0] t);
    logic [7:0] c;
    if (t <= 5'd9)
      c = 8'h30 + {3'b000, t};
    else if (t <= 5'd15)
      c = 8'h57 + {3'b000, t};   // 10 maps to 0x61 ('a')
    else begin
      case (t)
        5'd16:   c = 8'h28;
        5'd17:   c = 8'h29;
        5'd18:   c = 8'h2A;
        5'd19:   c = 8'h2B;
        default: c = 8'h2D;
      endcase
    end
    return c;
  endfunction

  assign wr_accept   = (state_reg == IDLE) && tok_wr && (tok_in <= 5'd20) &&
                       (count_reg != 5'd16);
  assign count_after = count_reg + {4'd0, wr_accept};
  assign end_req     = (state_reg == IDLE) && tok_wr && tok_last &&
                       (count_after != 5'd0);
  // With an empty buffer the first character is the token being written now,
  // which has not reached the buffer yet.
  assign first_tok   = (count_reg == 5'd0) ? tok_in : tok_buf_reg[0];
  assign busy        = (state_reg != IDLE);

`ifdef AEC_TX_CHECK_EN
  logic [4:0] tok_view [16];
  logic       chk_expect;   // an operand (digit or '(') is expected next
  logic [4:0] chk_depth;
  logic       err_reg;

  // The expression as it will be once the current write lands.
  for (genvar gi = 0; gi < 16; gi++) begin : g_view
    assign tok_view[gi] = (wr_accept && (count_reg == 5'(gi))) ? tok_in
                                                              : tok_buf_reg[gi];
  end

  always_comb begin
    chk_ok     = 1'b1;
    chk_expect = 1'b1;
    chk_depth  = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < count_after) begin
        if (tok_view[i] <= 5'd15) begin
          if (!chk_expect) chk_ok = 1'b0;
          chk_expect = 1'b0;
        end else if (tok_view[i] == 5'd16) begin
          if (!chk_expect) chk_ok = 1'b0;
          chk_depth = chk_depth + 5'd1;
        end else if (tok_view[i] == 5'd17) begin
          // ')' right after '(' or an operator also lands here as a failure
          if (chk_expect) chk_ok = 1'b0;
          if (chk_depth == 5'd0) chk_ok = 1'b0;
          else chk_depth = chk_depth - 5'd1;
        end else begin
          if (chk_expect) chk_ok = 1'b0;
          chk_expect = 1'b1;
        end
      end
    end
    if (chk_expect || (chk_depth != 5'd0)) chk_ok = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_reg <= 1'b0;
    else     err_reg <= end_req && !chk_ok;
  end
  assign err = err_reg;
`else
  assign chk_ok = 1'b1;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= 5'd0;
      idx_reg   <= 5'd0;
      ready     <= 1'b0;
      done      <= 1'b0;
      ascii_out <= 8'h00;
      result    <= 7'd0;
      for (int i = 0; i < 16; i++) tok_buf_reg[i] <= 5'd0;
    end else begin
      ready <= 1'b0;
      done  <= 1'b0;
      case (state_reg)
        IDLE: begin
          ascii_out <= 8'h00;
          if (wr_accept) tok_buf_reg[count_reg[3:0]] <= tok_in;
          if (end_req && chk_ok) begin
            count_reg <= count_after;
            ascii_out <= tok_char(first_tok);
            ready     <= 1'b1;
            idx_reg   <= 5'd1;
            state_reg <= SEND;
          end else if (end_req) begin
            count_reg <= 5'd0;
          end else begin
            count_reg <= count_after;
          end
        end
        SEND: begin
          if (idx_reg == count_reg) begin
            ascii_out <= 8'h3D;
            state_reg <= EQ;
          end else begin
            ascii_out <= tok_char(tok_buf_reg[idx_reg[3:0]]);
            idx_reg   <= idx_reg + 5'd1;
          end
        end
        EQ: begin
          ascii_out <= 8'h00;
          state_reg <= WAIT_RES;
        end
        default: begin   // WAIT_RES
          ascii_out <= 8'h00;
          if (res_valid) begin
            result    <= res_in;
            done      <= 1'b1;
            count_reg <= 5'd0;
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
